// File: rtl/msrv32_dbus_ahb_master_if.sv
// AHB-Lite bus bundle between the msrv32 data-side master and the slave fabric.
// master modport: drives haddr/htrans/hwrite/hsize/hburst/hprot/hwdata,
//                 samples hrdata/hready/hresp.
// slave modport : the mirror image, for the fabric or a testbench model.
interface msrv32_dbus_ahb_master_if;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [2:0]  hburst_out;
  logic [3:0]  hprot_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  modport master (
    output haddr_out, htrans_out, hwrite_out, hsize_out, hburst_out, hprot_out, hwdata_out,
    input  hrdata_in, hready_in, hresp_in
  );

  modport slave (
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hburst_out, hprot_out, hwdata_out,
    output hrdata_in, hready_in, hresp_in
  );
endinterface

// File: rtl/msrv32_dbus_ahb_master.sv
// msrv32 data-bus AHB-Lite master.
// Turns each core load/store request into one AHB-Lite SINGLE transfer, with at most
// one transfer outstanding. Handles wait states and the two-cycle ERROR response, and
// returns read data / ready / error to the core.
// Ports:
//   clk_in, rst_in (async, active low)
//   core_addr_in, core_wdata_in, core_wr_req_in, core_mask_in, core_htrans_in : core request
//   core_rdata_out, core_ready_out, core_err_out                              : core response
//   ahb (msrv32_dbus_ahb_master_if.master)                                    : AHB-Lite bus
// Optional build macro: MSRV32_DBUS_TIMEOUT_EN -- aborts a transfer after TIMEOUT_CYCLES
// consecutive hready_in-low cycles and reports it as an error.
module msrv32_dbus_ahb_master #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [3:0] HPROT_VALUE    = 4'b0011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic        core_wr_req_in,
  input  logic [3:0]  core_mask_in,
  input  logic [1:0]  core_htrans_in,
  output logic [31:0] core_rdata_out,
  output logic        core_ready_out,
  output logic        core_err_out,
  msrv32_dbus_ahb_master_if.master ahb
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  size_q;
  logic        wr_q, err_q;

  // request decode
  logic [2:0]  req_size;
  logic [1:0]  req_lo;
  logic        req_legal;
  logic [31:0] req_addr;

  // FSM strobes
  logic issue, bad_req, load_done, err_set;

  // Loads are always whole words; stores derive size and low address bits from the
  // byte mask. Masks that are not a naturally aligned byte/half/word are rejected.
  always_comb begin
    req_size  = 3'b010;
    req_lo    = 2'b00;
    req_legal = 1'b1;
    if (core_wr_req_in) begin
      case (core_mask_in)
        4'b1111: begin req_size = 3'b010; req_lo = 2'b00; end
        4'b0011: begin req_size = 3'b001; req_lo = 2'b00; end
        4'b1100: begin req_size = 3'b001; req_lo = 2'b10; end
        4'b0001: begin req_size = 3'b000; req_lo = 2'b00; end
        4'b0010: begin req_size = 3'b000; req_lo = 2'b01; end
        4'b0100: begin req_size = 3'b000; req_lo = 2'b10; end
        4'b1000: begin req_size = 3'b000; req_lo = 2'b11; end
        default: req_legal = 1'b0;
      endcase
    end
  end

  assign req_addr = {core_addr_in[31:2], req_lo};

`ifdef MSRV32_DBUS_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_hit;

  // The counter holds the number of low cycles already seen, so the TIMEOUT_CYCLES-th
  // consecutive low cycle is the one that aborts.
  assign timeout_hit = (state_q != IDLE) && !ahb.hready_in &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      to_cnt_q <= '0;
    else if (state_q == IDLE || ahb.hready_in || state_d != state_q)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    bad_req   = 1'b0;
    load_done = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_htrans_in == HTRANS_NONSEQ) begin
          if (req_legal) begin
            issue   = 1'b1;
            state_d = ADDR;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      ADDR: if (ahb.hready_in) state_d = DATA;
      DATA: begin
        if (ahb.hready_in) begin
          // hready with hresp=1 is a malformed ERROR response; still report it.
          if (ahb.hresp_in) err_set = 1'b1;
          else              load_done = !wr_q;
          state_d = IDLE;
        end else if (ahb.hresp_in) begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (ahb.hready_in) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d   = IDLE;
      err_set   = 1'b1;
      load_done = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 3'b010;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_set | bad_req;
      if (issue) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        wr_q    <= core_wr_req_in;
        wdata_q <= core_wdata_in;
      end
      if (load_done) rdata_q <= ahb.hrdata_in;
    end
  end

  assign ahb.htrans_out = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.haddr_out  = addr_q;
  assign ahb.hwrite_out = wr_q;
  assign ahb.hsize_out  = size_q;
  assign ahb.hburst_out = 3'b000;
  assign ahb.hprot_out  = HPROT_VALUE;
  assign ahb.hwdata_out = wdata_q;

  assign core_rdata_out = rdata_q;
  assign core_ready_out = (state_q == IDLE);
  assign core_err_out   = err_q;

endmodule

// File: tb/tb_msrv32_dbus_ahb_master.sv
module tb_msrv32_dbus_ahb_master;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] core_addr_in = '0;
  logic [31:0] core_wdata_in = '0;
  logic        core_wr_req_in = 1'b0;
  logic [3:0]  core_mask_in = '0;
  logic [1:0]  core_htrans_in = '0;
  logic [31:0] core_rdata_out;
  logic        core_ready_out;
  logic        core_err_out;

  int checks = 0;
  int failures = 0;

  msrv32_dbus_ahb_master_if bus();

  msrv32_dbus_ahb_master #(.TIMEOUT_CYCLES(4), .HPROT_VALUE(4'b0011)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .core_addr_in(core_addr_in), .core_wdata_in(core_wdata_in),
    .core_wr_req_in(core_wr_req_in), .core_mask_in(core_mask_in),
    .core_htrans_in(core_htrans_in), .core_rdata_out(core_rdata_out),
    .core_ready_out(core_ready_out), .core_err_out(core_err_out),
    .ahb(bus.master)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] hrdata;
    logic        illegal;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    core_addr_in   = v.addr;
    core_wdata_in  = v.wdata;
    core_wr_req_in = v.wr;
    core_mask_in   = v.mask;
    core_htrans_in = 2'b10;
  endtask

  // Zero-wait transaction; every step happens at a negedge: sample, then drive.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk_in);
    chk({tag, " ready_T"}, 32'(core_ready_out), 32'd1);
    bus.hready_in = 1'b1;
    bus.hresp_in  = 1'b0;
    drive_req(v);
    @(negedge clk_in);  // T+1
    core_htrans_in = 2'b00;
    if (v.illegal) begin
      chk({tag, " err_T1"}, 32'(core_err_out), 32'd1);
      chk({tag, " htrans_T1"}, 32'(bus.htrans_out), 32'd0);
      chk({tag, " ready_T1"}, 32'(core_ready_out), 32'd1);
      @(negedge clk_in);
      chk({tag, " err_T2"}, 32'(core_err_out), 32'd0);
      chk({tag, " htrans_T2"}, 32'(bus.htrans_out), 32'd0);
      chk({tag, " rdata"}, core_rdata_out, v.exp_rdata);
    end else begin
      chk({tag, " htrans_T1"}, 32'(bus.htrans_out), 32'h2);
      chk({tag, " haddr"}, bus.haddr_out, v.exp_haddr);
      chk({tag, " hsize"}, 32'(bus.hsize_out), 32'(v.exp_hsize));
      chk({tag, " hwrite"}, 32'(bus.hwrite_out), 32'(v.wr));
      chk({tag, " ready_T1"}, 32'(core_ready_out), 32'd0);
      @(negedge clk_in);  // T+2 data phase
      chk({tag, " htrans_T2"}, 32'(bus.htrans_out), 32'd0);
      chk({tag, " ready_T2"}, 32'(core_ready_out), 32'd0);
      if (v.wr) chk({tag, " hwdata"}, bus.hwdata_out, v.wdata);
      bus.hrdata_in = v.hrdata;
      @(negedge clk_in);  // T+3
      chk({tag, " ready_T3"}, 32'(core_ready_out), 32'd1);
      chk({tag, " rdata"}, core_rdata_out, v.exp_rdata);
      chk({tag, " err_T3"}, 32'(core_err_out), 32'd0);
    end
  endtask

  initial begin
    bus.hrdata_in = '0;
    bus.hready_in = 1'b1;
    bus.hresp_in  = 1'b0;

    //           addr          wdata         wr    mask     hrdata        ill   haddr         hsize   rdata
    vecs[0] = '{32'h1000_0006, 32'h0,        1'b0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 32'h1000_0004, 3'b010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 32'h00AB_0000, 1'b1, 4'b0100, 32'h5555_5555, 1'b0, 32'h0000_0022, 3'b000, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0103, 32'h1122_3344, 1'b1, 4'b1111, 32'h5555_5555, 1'b0, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0041, 32'hBEEF_0000, 1'b1, 4'b1100, 32'h5555_5555, 1'b0, 32'h0000_0042, 3'b001, 32'hDEAD_BEEF};
    vecs[4] = '{32'h0000_0043, 32'h0000_1234, 1'b1, 4'b0011, 32'h5555_5555, 1'b0, 32'h0000_0040, 3'b001, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_0050, 32'h7700_0000, 1'b1, 4'b1000, 32'h5555_5555, 1'b0, 32'h0000_0053, 3'b000, 32'hDEAD_BEEF};
    vecs[6] = '{32'h0000_0060, 32'h0000_9900, 1'b1, 4'b0010, 32'h5555_5555, 1'b0, 32'h0000_0061, 3'b000, 32'hDEAD_BEEF};
    vecs[7] = '{32'h0000_0070, 32'h00FF_00FF, 1'b1, 4'b0101, 32'h5555_5555, 1'b1, 32'h0,          3'b000, 32'hDEAD_BEEF};
    vecs[8] = '{32'h0000_0080, 32'h0,        1'b1, 4'b0000, 32'h5555_5555, 1'b1, 32'h0,          3'b000, 32'hDEAD_BEEF};
    vecs[9] = '{32'hFFFF_FFFF, 32'h0,        1'b0, 4'b0000, 32'h0BAD_F00D, 1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0BAD_F00D};

    // reset state
    @(negedge clk_in);
    chk("rst htrans", 32'(bus.htrans_out), 32'd0);
    chk("rst haddr", bus.haddr_out, 32'd0);
    chk("rst hwrite", 32'(bus.hwrite_out), 32'd0);
    chk("rst hsize", 32'(bus.hsize_out), 32'h2);
    chk("rst hwdata", bus.hwdata_out, 32'd0);
    chk("rst rdata", core_rdata_out, 32'd0);
    chk("rst err", 32'(core_err_out), 32'd0);
    chk("rst ready", 32'(core_ready_out), 32'd1);
    chk("hburst", 32'(bus.hburst_out), 32'd0);
    chk("hprot", 32'(bus.hprot_out), 32'h3);
    @(negedge clk_in);
    rst_in = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Load with 2 address-phase and 3 data-phase wait states
    @(negedge clk_in);
    drive_req('{32'h0000_0200, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 3'b0, 32'h0});
    @(negedge clk_in);  // ADDR
    core_htrans_in = 2'b00;
    bus.hready_in = 1'b0;
    @(negedge clk_in);
    chk("aw htrans hold", 32'(bus.htrans_out), 32'h2);
    chk("aw haddr hold", bus.haddr_out, 32'h200);
    @(negedge clk_in);
    chk("aw htrans hold2", 32'(bus.htrans_out), 32'h2);
    bus.hready_in = 1'b1;
    @(negedge clk_in);  // DATA
    chk("dw htrans", 32'(bus.htrans_out), 32'd0);
    bus.hready_in = 1'b0;
    bus.hrdata_in = 32'h1111_1111;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk_in);
      chk("dw ready low", 32'(core_ready_out), 32'd0);
      chk("dw rdata old", core_rdata_out, 32'h0BAD_F00D);
      if (w == 2) begin
        bus.hready_in = 1'b1;
        bus.hrdata_in = 32'hCAFE_F00D;
      end
    end
    @(negedge clk_in);
    chk("dw ready", 32'(core_ready_out), 32'd1);
    chk("dw rdata", core_rdata_out, 32'hCAFE_F00D);

    // Store with ERROR response
    drive_req('{32'h0000_0300, 32'hA5A5_A5A5, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 3'b0, 32'h0});
    @(negedge clk_in);  // ADDR
    core_htrans_in = 2'b00;
    @(negedge clk_in);  // DATA
    bus.hready_in = 1'b0;
    bus.hresp_in  = 1'b1;
    @(negedge clk_in);  // ERR
    chk("er err early", 32'(core_err_out), 32'd0);
    chk("er ready low", 32'(core_ready_out), 32'd0);
    bus.hready_in = 1'b1;
    @(negedge clk_in);
    chk("er err pulse", 32'(core_err_out), 32'd1);
    chk("er ready", 32'(core_ready_out), 32'd1);
    chk("er rdata", core_rdata_out, 32'hCAFE_F00D);
    bus.hresp_in = 1'b0;
    @(negedge clk_in);
    chk("er err one", 32'(core_err_out), 32'd0);

`ifdef MSRV32_DBUS_TIMEOUT_EN
    // hready stuck low from the address phase: abort on the 4th low cycle
    drive_req('{32'h0000_0400, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 3'b0, 32'h0});
    @(negedge clk_in);
    core_htrans_in = 2'b00;
    bus.hready_in = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk_in);
      chk("to no err", 32'(core_err_out), 32'd0);
    end
    @(negedge clk_in);
    chk("to err", 32'(core_err_out), 32'd1);
    chk("to htrans", 32'(bus.htrans_out), 32'd0);
    chk("to ready", 32'(core_ready_out), 32'd1);
    bus.hready_in = 1'b1;
    @(negedge clk_in);
`endif

    // Reset during the data phase
    drive_req('{32'h0000_0500, 32'h1234_5678, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 3'b0, 32'h0});
    @(negedge clk_in);
    core_htrans_in = 2'b00;
    @(negedge clk_in);  // DATA
    bus.hready_in = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("mr htrans", 32'(bus.htrans_out), 32'd0);
    chk("mr ready", 32'(core_ready_out), 32'd1);
    chk("mr haddr", bus.haddr_out, 32'd0);
    chk("mr rdata", core_rdata_out, 32'd0);
    @(negedge clk_in);
    chk("mr err", 32'(core_err_out), 32'd0);
    rst_in = 1'b1;
    bus.hready_in = 1'b1;
    run_vec(99, '{32'h0000_0604, 32'h0, 1'b0, 4'b0000, 32'h7654_3210, 1'b0, 32'h0000_0604, 3'b010, 32'h7654_3210});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
